// File: rtl/pad_pkg.sv
// Shared constants and state type for the zero-padded frame buffer.
// The window reader imports the same geometry.
package pad_pkg;

    localparam int unsigned IMG_W       = 256;
    localparam int unsigned IMG_H       = 32;
    localparam int unsigned PAD_W       = IMG_W + 2;
    localparam int unsigned PAD_H       = IMG_H + 2;
    localparam int unsigned FRAME_WORDS = PAD_W * PAD_H;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

endpackage

// File: rtl/frame_pad_writer_if.sv
// Pixel-stream input plus padded-RAM write port of the frame pad writer.
interface frame_pad_writer_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 14
);

    logic              in_valid;
    logic [PIX_W-1:0]  in_pixel;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;

    modport slave (
        input  in_valid,
        input  in_pixel,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_pixel,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/pad_raster_counter.sv
// Row/column/address walker over the padded frame in raster order.
// Flags border positions and the final position of the frame.
module pad_raster_counter #(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              is_border,
    output logic              is_last
);

    localparam int unsigned PAD_W = IMG_W + 2;
    localparam int unsigned PAD_H = IMG_H + 2;
    localparam int unsigned CW    = $clog2(PAD_W);
    localparam int unsigned RW    = $clog2(PAD_H);

    logic [RW-1:0]     r_q;
    logic [CW-1:0]     c_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_col;
    logic              last_row;

    assign last_col  = (c_q == CW'(PAD_W - 1));
    assign last_row  = (r_q == RW'(PAD_H - 1));
    assign is_last   = last_col && last_row;
    assign is_border = (r_q == '0) || last_row || (c_q == '0) || last_col;
    assign addr      = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else if (clear) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else if (advance) begin
            // Wrap to the origin after the last word so r never leaves its range.
            if (last_col) begin
                c_q <= '0;
                r_q <= last_row ? '0 : r_q + RW'(1);
            end else begin
                c_q <= c_q + CW'(1);
            end
            addr_q <= is_last ? '0 : addr_q + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/frame_pad_writer.sv
// Streams one raw frame into the zero-padded frame RAM: border words are
// written as zero without consuming input, interior words take one pixel each.
module frame_pad_writer #(
    parameter int unsigned IMG_W  = pad_pkg::IMG_W,
    parameter int unsigned IMG_H  = pad_pkg::IMG_H,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    frame_pad_writer_if.slave  bus,
    output logic               busy,
    output logic               done
);

    import pad_pkg::*;

    state_e            state_q;
    state_e            state_d;
    logic              clear;
    logic              write_now;
    logic [ADDR_W-1:0] cnt_addr;
    logic              is_border;
    logic              is_last;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  wdata_q;

    pad_raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .advance   (write_now),
        .addr      (cnt_addr),
        .is_border (is_border),
        .is_last   (is_last)
    );

    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        write_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    clear   = 1'b1;
                end
            end
            SCAN: begin
                write_now = is_border || bus.in_valid;
                if (write_now && is_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and data hold their last values between write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= write_now;
            if (write_now) begin
                addr_q  <= cnt_addr;
                wdata_q <= is_border ? '0 : bus.in_pixel;
            end
        end
    end

    assign bus.in_ready  = (state_q == SCAN) && !is_border;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_frame_pad_writer.sv
// Directed bench for frame_pad_writer at default geometry plus a 4x2 instance.
module tb_frame_pad_writer;

    localparam int unsigned FW = 8772;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic sstart;
    logic sbusy;
    logic sdone;

    frame_pad_writer_if #(.PIX_W(8), .ADDR_W(14)) mif ();
    frame_pad_writer_if #(.PIX_W(8), .ADDR_W(5))  sif ();

    frame_pad_writer #(
        .IMG_W  (256),
        .IMG_H  (32),
        .PIX_W  (8),
        .ADDR_W (14)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (mif),
        .busy  (busy),
        .done  (done)
    );

    frame_pad_writer #(
        .IMG_W  (4),
        .IMG_H  (2),
        .PIX_W  (8),
        .ADDR_W (5)
    ) u_small (
        .clk   (clk),
        .rst   (rst),
        .start (sstart),
        .bus   (sif),
        .busy  (sbusy),
        .done  (sdone)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ram  [0:FW-1];
    int         wcnt [0:FW-1];
    int ncyc = 0;
    int idx, wr_total, seq_err, exp_next, done_cnt, done_cyc, done_addr, busy_cyc, stall_cnt;
    bit done_we, fire, busy_prev, bursty;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int a);
        int r, c;
        r = a / 258;
        c = a % 258;
        if (r == 0 || r == 33 || c == 0 || c == 257) return 8'h00;
        return 8'(c - 1);
    endfunction

    task automatic clear_stats();
        for (int a = 0; a < FW; a++) begin
            ram[a]  = 8'h5A;
            wcnt[a] = 0;
        end
        wr_total  = 0;
        seq_err   = 0;
        exp_next  = 0;
        done_cnt  = 0;
        done_we   = 1'b0;
        idx       = 0;
        fire      = 1'b0;
        stall_cnt = 0;
    endtask

    // Sample outputs of the previous rising edge, then drive the next inputs.
    task automatic step();
        bit v;
        @(negedge clk);
        ncyc++;
        if (mif.mem_we) begin
            wr_total++;
            if (int'(mif.mem_addr) != exp_next) seq_err++;
            exp_next = int'(mif.mem_addr) + 1;
            if (mif.mem_addr < 14'(FW)) begin
                ram[mif.mem_addr]  = mif.mem_wdata;
                wcnt[mif.mem_addr] = wcnt[mif.mem_addr] + 1;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc  = ncyc;
            done_addr = int'(mif.mem_addr);
            done_we   = mif.mem_we;
        end
        if (busy && !busy_prev) busy_cyc = ncyc;
        busy_prev = busy;
        if (fire) idx++;
        v = !(bursty && (ncyc % 3 == 0));
        mif.in_valid = v;
        mif.in_pixel = mif.in_ready ? idx[7:0] : 8'hAA;
        if (mif.in_ready && !v) stall_cnt++;
        fire = v && mif.in_ready;
    endtask

    task automatic run_frame(input bit bursty_i, input bit poke_i);
        clear_stats();
        bursty = bursty_i;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (done_cnt != 0) break;
            start = poke_i && (i == 3000);
        end
        // A start presented in the DONE cycle must be ignored.
        start = poke_i;
        step();
        start = 1'b0;
        repeat (20) step();
    endtask

    task automatic check_frame(input string pfx);
        int errs;
        errs = 0;
        for (int a = 0; a < FW; a++) begin
            if (wcnt[a] != 1 || ram[a] != exp_pix(a)) errs++;
        end
        check_eq({pfx, "_writes"}, wr_total, 8772);
        check_eq({pfx, "_seq_err"}, seq_err, 0);
        check_eq({pfx, "_done_cnt"}, done_cnt, 1);
        check_eq({pfx, "_done_addr"}, done_addr, 8771);
        check_eq({pfx, "_done_we"}, done_we, 1);
        check_eq({pfx, "_image_errs"}, errs, 0);
        check_eq({pfx, "_a258"}, ram[258], 8'h00);
        check_eq({pfx, "_a259"}, ram[259], 8'h00);
        check_eq({pfx, "_a260"}, ram[260], 8'h01);
        check_eq({pfx, "_a514"}, ram[514], 8'hFF);
        check_eq({pfx, "_a515"}, ram[515], 8'h00);
        check_eq({pfx, "_a516"}, ram[516], 8'h00);
        check_eq({pfx, "_a517"}, ram[517], 8'h00);
        check_eq({pfx, "_a8771"}, ram[8771], 8'h00);
        check_eq({pfx, "_busy_after"}, busy, 0);
        check_eq({pfx, "_ready_after"}, mif.in_ready, 0);
    endtask

    logic [7:0] sram [0:23];
    int exp_s [0:23] = '{0, 0, 0, 0, 0, 0,
                         0, 0, 1, 2, 3, 0,
                         0, 4, 5, 6, 7, 0,
                         0, 0, 0, 0, 0, 0};

    initial begin
        int snap, swr, sdone_cnt, sidx;
        bit sfire;
        rst          = 1'b1;
        start        = 1'b0;
        sstart       = 1'b0;
        bursty       = 1'b0;
        busy_prev    = 1'b0;
        mif.in_valid = 1'b0;
        mif.in_pixel = 8'h00;
        sif.in_valid = 1'b0;
        sif.in_pixel = 8'h00;
        #3;
        check_eq("rst_we", mif.mem_we, 0);
        check_eq("rst_addr", mif.mem_addr, 0);
        check_eq("rst_wdata", mif.mem_wdata, 0);
        check_eq("rst_ready", mif.in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with valid high and 0xAA on the bus: nothing consumed or written.
        clear_stats();
        repeat (10) step();
        check_eq("idle_writes", wr_total, 0);
        check_eq("idle_ready", mif.in_ready, 0);
        check_eq("idle_busy", busy, 0);

        // Full-rate frame with extra starts mid-scan and during DONE.
        run_frame(1'b0, 1'b1);
        check_frame("full");
        check_eq("full_time", done_cyc - busy_cyc, 8772);

        // Bursty source; a fresh start in IDLE begins again at address 0.
        run_frame(1'b1, 1'b0);
        check_frame("burst");
        check_eq("burst_stalls_nz", stall_cnt > 0, 1);
        check_eq("burst_time", done_cyc - busy_cyc, 8772 + stall_cnt);

        // Asynchronous reset in the interior part of a frame.
        clear_stats();
        bursty = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 6000 && wr_total < 4000; i++) step();
        check_eq("pre_rst_writes", wr_total, 4000);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_we", mif.mem_we, 0);
        check_eq("arst_addr", mif.mem_addr, 0);
        check_eq("arst_wdata", mif.mem_wdata, 0);
        check_eq("arst_ready", mif.in_ready, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        repeat (3) step();
        rst = 1'b0;
        snap = wr_total;
        repeat (10) step();
        check_eq("post_rst_writes", wr_total - snap, 0);
        check_eq("post_rst_busy", busy, 0);
        run_frame(1'b0, 1'b0);
        check_frame("rerun");

        // Reduced 4x2 geometry, full RAM compare.
        for (int a = 0; a < 24; a++) sram[a] = 8'hEE;
        swr       = 0;
        sdone_cnt = 0;
        sidx      = 0;
        sfire     = 1'b0;
        sstart    = 1'b1;
        @(negedge clk);
        sstart    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sif.mem_we) begin
                swr++;
                if (sif.mem_addr < 5'd24) sram[sif.mem_addr] = sif.mem_wdata;
            end
            if (sdone) sdone_cnt++;
            if (sfire) sidx++;
            sif.in_valid = 1'b1;
            sif.in_pixel = sif.in_ready ? sidx[7:0] : 8'hAA;
            sfire = sif.in_ready;
        end
        check_eq("small_writes", swr, 24);
        check_eq("small_done_cnt", sdone_cnt, 1);
        for (int a = 0; a < 24; a++) begin
            check_eq($sformatf("small_a%0d", a), sram[a], exp_s[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_pad_writer.md
Name: frame_pad_writer

Overview:
- Loads one grayscale frame into the zero-padded frame memory consumed by the 3x3 window reader.
- Takes a raw 256-wide raster pixel stream with a valid/ready handshake.
- Emits a write port that fills the padded (IMG_W+2)x(IMG_H+2) buffer in raster order: zero border, image interior.
- Sits between the pixel source and the frame RAM, ahead of the window reader/convolution pipeline.

Parameters:
- IMG_W, 256, image width in pixels (unpadded)
- IMG_H, 32, image height in rows (unpadded)
- PIX_W, 8, pixel width in bits
- ADDR_W, 14, write address width; must satisfy (IMG_W+2)*(IMG_H+2) <= 2**ADDR_W (default frame = 258*34 = 8772 words)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to load a frame; sampled only in IDLE
- in_valid  input  1  in_pixel holds a valid pixel
- in_pixel  input  PIX_W  raw pixel, raster order, row 0 first
- in_ready  output  1  block accepts in_pixel this cycle
- mem_we  output  1  write strobe to padded frame RAM
- mem_addr  output  ADDR_W  write address = r*(IMG_W+2)+c
- mem_wdata  output  PIX_W  write data
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse, frame fully written

Behaviour:
- Reset (async, any state): state=IDLE, r=0, c=0, and all outputs 0 (mem_addr=0, mem_wdata=0, mem_we=0, in_ready=0, busy=0, done=0). A reset mid-frame abandons the frame; no further writes occur.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on start=1; r and c are cleared to 0.
  - SCAN -> DONE on the edge that issues the write for r=IMG_H+1, c=IMG_W+1.
  - DONE -> IDLE unconditionally on the next edge.
- Border position: r==0, r==IMG_H+1, c==0, or c==IMG_W+1.
  - Writes 0 without consuming input.
  - Advances one position per cycle.
  - in_ready=0.
- Interior position: in_ready=1.
  - On an edge with in_valid=1: write in_pixel, then advance.
  - in_valid=0: no write, and r/c hold.
- in_ready is a Moore output: a function of state/r/c only, never of in_valid. It is 0 in IDLE and DONE. Input presented then is ignored, not consumed.
- Advance: c wraps from IMG_W+1 to 0 and increments r.
- mem_we, mem_addr, mem_wdata are registered.
  - The write decided at edge k appears on the ports in the cycle after edge k. Latency is 1 cycle.
  - mem_we=0 in any cycle with no write; mem_addr/mem_wdata then hold their last values.
- Addresses are strictly increasing by 1; every address 0..FRAME_WORDS-1 is written exactly once per frame.
- done=1 in the DONE cycle, coincident with the final mem_we pulse (addr FRAME_WORDS-1).
- start while busy is ignored. start in the DONE cycle is ignored; it must be reasserted in IDLE.
- Frame totals (defaults): 8772 writes, of which 8192 are input pixels and 580 are border zeros.
- Minimum frame time with in_valid held high: 8772 cycles from the SCAN entry edge to the DONE cycle.
- Address arithmetic is carried in ADDR_W bits, with no overflow for legal parameters. r and c use clog2-sized counters.

Decomposition:
- Shared package pad_pkg holds:
  - IMG_W, IMG_H, PAD_W=IMG_W+2, PAD_H=IMG_H+2, FRAME_WORDS=PAD_W*PAD_H
  - the state enum {IDLE, SCAN, DONE}
- The window reader uses the same constants from pad_pkg.
- One sub-module: pad_raster_counter. It holds the r/c/address counters and generates is_border and is_last, with an advance input.
- The FSM, handshake, and write-port registers stay in frame_pad_writer.

Test Plan:
- Reset then start with in_valid held 1 and pixel = index mod 256:
  - mem_we pulses exactly 8772 times.
  - Addrs 0..257 write 0; addr 258 writes 0; addr 259 writes 0x00 (pixel 0); addr 516 writes 0x00; addr 517 writes 0.
  - done pulses with addr 8771, and 8772 cycles after SCAN entry.
- Bursty input, in_valid low on every third cycle:
  - No mem_we while waiting at interior positions.
  - Final RAM image is identical to the first test.
  - done is delayed by exactly the number of stalled interior cycles.
- in_valid=1 with in_pixel=0xAA while IDLE and while in the top-border rows:
  - in_ready=0, no write of 0xAA, and the first consumed pixel lands at addr 259.
- start pulsed again mid-SCAN and during DONE: ignored, and exactly one frame's writes occur. A later start in IDLE starts a new frame from addr 0.
- rst asserted asynchronously at interior addr ~4000: all outputs 0 immediately, state IDLE. A new start rewrites from addr 0 with the correct border.
- Reduced parameters IMG_W=4, IMG_H=2 with full RAM dump compare:
  - 24 writes total.
  - Interior addrs 7,8,9,10,13,14,15,16 carry pixels 0..7; all other addrs are 0.
